// File: rtl/execute_cycle.sv
// execute_cycle -- execute stage of a 5-stage RV32-style pipeline plus the E/M
// pipeline register.
//
// Ports:
//   clk, rst            single clock; synchronous active-low reset
//   *_E control inputs  RegWrite, MemWrite, ResultSrc, RD, PCPlus4 are passed to M
//   Branch_E, Jump_E    branch / jump qualifiers for the redirect request
//   ALUSrc_E            1 selects Imm_Ext_E as ALU operand B
//   ALUControl_E        ALU operation; Funct3_E branch condition
//   ForwardA_E/B_E      operand forwarding selects (00 reg, 01 ResultW, 10 ALU_Result_M)
//   RD1_E, RD2_E        register-file read data
//   Imm_Ext_E, PC_E     immediate and instruction PC
//   ResultW             writeback result used for forwarding
//   *_M outputs         registered copies for the memory stage
//   PCSrc_E, PCTarget_E combinational redirect request and target
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_E,
  input  logic        MemWrite_E,
  input  logic [1:0]  ResultSrc_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] PCPlus4_E,
  input  logic        Branch_E,
  input  logic        Jump_E,
  input  logic        ALUSrc_E,
  input  logic [2:0]  ALUControl_E,
  input  logic [2:0]  Funct3_E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] ResultW,
  output logic        RegWrite_M,
  output logic        MemWrite_M,
  output logic [1:0]  ResultSrc_M,
  output logic [4:0]  RD_M,
  output logic [31:0] PCPlus4_M,
  output logic [31:0] ALU_Result_M,
  output logic [31:0] WriteData_M,
  output logic        PCSrc_E,
  output logic [31:0] PCTarget_E
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        branch_taken;

  // Operand forwarding; select 11 is unused and falls back to the register value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_Result_M;
      default: src_a = RD1_E;
    endcase
    fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_Result_M;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;
  end

  always_comb begin
    alu_result = 32'd0;
    case (ALUControl_E)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      3'b110: alu_result = src_a << src_b[4:0];
      3'b111: alu_result = src_a >> src_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  // Branch compares always use the forwarded register operand, never the immediate.
  always_comb begin
    branch_taken = 1'b0;
    case (Funct3_E)
      3'b000: branch_taken = (src_a == fwd_b);
      3'b001: branch_taken = (src_a != fwd_b);
      3'b100: branch_taken = ($signed(src_a) <  $signed(fwd_b));
      3'b101: branch_taken = ($signed(src_a) >= $signed(fwd_b));
      3'b110: branch_taken = (src_a <  fwd_b);
      3'b111: branch_taken = (src_a >= fwd_b);
      default: branch_taken = 1'b0;
    endcase
  end

  assign PCSrc_E    = Jump_E | (Branch_E & branch_taken);
  assign PCTarget_E = PC_E + Imm_Ext_E;

  // E/M pipeline register: loads every cycle; store data is the forwarded B,
  // not the immediate-muxed ALU operand.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWrite_M   <= 1'b0;
      MemWrite_M   <= 1'b0;
      ResultSrc_M  <= 2'b00;
      RD_M         <= 5'd0;
      PCPlus4_M    <= 32'd0;
      ALU_Result_M <= 32'd0;
      WriteData_M  <= 32'd0;
    end else begin
      RegWrite_M   <= RegWrite_E;
      MemWrite_M   <= MemWrite_E;
      ResultSrc_M  <= ResultSrc_E;
      RD_M         <= RD_E;
      PCPlus4_M    <= PCPlus4_E;
      ALU_Result_M <= alu_result;
      WriteData_M  <= fwd_b;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle -- directed self-checking bench for execute_cycle.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E;
  logic [1:0]  ResultSrc_E, ForwardA_E, ForwardB_E;
  logic [4:0]  RD_E;
  logic [2:0]  ALUControl_E, Funct3_E;
  logic [31:0] PCPlus4_E, RD1_E, RD2_E, Imm_Ext_E, PC_E, ResultW;
  logic        RegWrite_M, MemWrite_M, PCSrc_E;
  logic [1:0]  ResultSrc_M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4_M, ALU_Result_M, WriteData_M, PCTarget_E;

  int checks;
  int passes;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E),
    .RD_E(RD_E), .PCPlus4_E(PCPlus4_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
    .ALUSrc_E(ALUSrc_E), .ALUControl_E(ALUControl_E), .Funct3_E(Funct3_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .ResultW(ResultW),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .RD_M(RD_M), .PCPlus4_M(PCPlus4_M), .ALU_Result_M(ALU_Result_M),
    .WriteData_M(WriteData_M), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance past the next rising edge, sampling away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite_E = 0; MemWrite_E = 0; Branch_E = 0; Jump_E = 0; ALUSrc_E = 0;
    ResultSrc_E = 0; ForwardA_E = 0; ForwardB_E = 0; RD_E = 0;
    ALUControl_E = 0; Funct3_E = 0; PCPlus4_E = 0; RD1_E = 0; RD2_E = 0;
    Imm_Ext_E = 0; PC_E = 0; ResultW = 0;
  endtask

  task automatic randomize_inputs();
    RegWrite_E = 1'($urandom); MemWrite_E = 1'($urandom); Branch_E = 1'($urandom);
    Jump_E = 1'($urandom); ALUSrc_E = 1'($urandom); ResultSrc_E = 2'($urandom);
    ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom); RD_E = 5'($urandom) | 5'd1;
    ALUControl_E = 3'($urandom); Funct3_E = 3'($urandom);
    PCPlus4_E = $urandom | 32'd1; RD1_E = $urandom | 32'd1; RD2_E = $urandom | 32'd1;
    Imm_Ext_E = $urandom; PC_E = $urandom; ResultW = $urandom | 32'd1;
  endtask

  task automatic check_m_zero(input string tag);
    check_output({tag, " RegWrite_M"},   32'(RegWrite_M),  32'd0);
    check_output({tag, " MemWrite_M"},   32'(MemWrite_M),  32'd0);
    check_output({tag, " ResultSrc_M"},  32'(ResultSrc_M), 32'd0);
    check_output({tag, " RD_M"},         32'(RD_M),        32'd0);
    check_output({tag, " PCPlus4_M"},    PCPlus4_M,        32'd0);
    check_output({tag, " ALU_Result_M"}, ALU_Result_M,     32'd0);
    check_output({tag, " WriteData_M"},  WriteData_M,      32'd0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    clear_inputs();
    rst = 1'b0;

    // Reset held for two edges with random inputs.
    randomize_inputs();
    tick();
    check_m_zero("reset1");
    randomize_inputs();
    tick();
    check_m_zero("reset2");

    // Combinational target still follows inputs during reset.
    PC_E = 32'h1000; Imm_Ext_E = 32'h24;
    #1;
    check_output("reset PCTarget_E", PCTarget_E, 32'h0000_1024);

    // Release and load: sub 7-5, with control fields passed through.
    clear_inputs();
    rst = 1'b1;
    RegWrite_E = 1; ResultSrc_E = 2'b01; RD_E = 5'd9; PCPlus4_E = 32'h44;
    RD1_E = 32'd7; RD2_E = 32'd5; ALUControl_E = 3'b001;
    tick();
    check_output("sub ALU_Result_M", ALU_Result_M, 32'd2);
    check_output("sub WriteData_M",  WriteData_M,  32'd5);
    check_output("sub RegWrite_M",   32'(RegWrite_M),  32'd1);
    check_output("sub ResultSrc_M",  32'(ResultSrc_M), 32'd1);
    check_output("sub RD_M",         32'(RD_M),        32'd9);
    check_output("sub PCPlus4_M",    PCPlus4_M,        32'h44);

    // Set up ALU_Result_M = 0x10, then forward it (A=10) and ResultW (B=01).
    clear_inputs();
    RD1_E = 32'h10; ALUControl_E = 3'b000;
    tick();
    check_output("pre-fwd ALU_Result_M", ALU_Result_M, 32'h10);
    clear_inputs();
    RD1_E = 32'h111; RD2_E = 32'h222; ResultW = 32'h20;
    ForwardA_E = 2'b10; ForwardB_E = 2'b01;
    tick();
    check_output("fwd ALU_Result_M", ALU_Result_M, 32'h30);
    check_output("fwd WriteData_M",  WriteData_M,  32'h20);

    // Forward select 11 behaves like 00.
    clear_inputs();
    RD1_E = 32'd5; RD2_E = 32'd6; ResultW = 32'h999;
    ForwardA_E = 2'b11; ForwardB_E = 2'b11;
    tick();
    check_output("fwd11 ALU_Result_M", ALU_Result_M, 32'd11);
    check_output("fwd11 WriteData_M",  WriteData_M,  32'd6);

    // ALU operations and wraparound.
    clear_inputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; ALUControl_E = 3'b000;
    tick();
    check_output("add wrap", ALU_Result_M, 32'd0);
    RD1_E = 32'd0; RD2_E = 32'd1; ALUControl_E = 3'b001;
    tick();
    check_output("sub wrap", ALU_Result_M, 32'hFFFF_FFFF);
    RD1_E = 32'hF0F0; RD2_E = 32'h0FF0; ALUControl_E = 3'b010;
    tick();
    check_output("and", ALU_Result_M, 32'h00F0);
    ALUControl_E = 3'b011;
    tick();
    check_output("or", ALU_Result_M, 32'hFFF0);
    ALUControl_E = 3'b100;
    tick();
    check_output("xor", ALU_Result_M, 32'hFF00);
    RD1_E = 32'hFFFF_FFFE; RD2_E = 32'd3; ALUControl_E = 3'b101;
    tick();
    check_output("slt signed", ALU_Result_M, 32'd1);
    RD1_E = 32'd3; RD2_E = 32'hFFFF_FFFE;
    tick();
    check_output("slt signed false", ALU_Result_M, 32'd0);
    RD1_E = 32'h8000_0000; RD2_E = 32'h24; ALUControl_E = 3'b111;
    tick();
    check_output("srl uses low 5 bits", ALU_Result_M, 32'h0800_0000);

    // Branch conditions: SrcA = -1, B = 1.
    clear_inputs();
    Branch_E = 1; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    Funct3_E = 3'b100; #1;
    check_output("blt taken", 32'(PCSrc_E), 32'd1);
    Funct3_E = 3'b110; #1;
    check_output("bltu not taken", 32'(PCSrc_E), 32'd0);
    Funct3_E = 3'b101; #1;
    check_output("bge not taken", 32'(PCSrc_E), 32'd0);
    Funct3_E = 3'b111; #1;
    check_output("bgeu taken", 32'(PCSrc_E), 32'd1);
    Funct3_E = 3'b000; #1;
    check_output("beq not taken", 32'(PCSrc_E), 32'd0);
    Funct3_E = 3'b001; #1;
    check_output("bne taken", 32'(PCSrc_E), 32'd1);
    Funct3_E = 3'b011; #1;
    check_output("f3 011 never", 32'(PCSrc_E), 32'd0);
    Funct3_E = 3'b001; Branch_E = 0; #1;
    check_output("no branch", 32'(PCSrc_E), 32'd0);
    // Branch compares the forwarded register even when ALUSrc picks the immediate.
    Branch_E = 1; Funct3_E = 3'b000; RD2_E = 32'hFFFF_FFFF; ALUSrc_E = 1; Imm_Ext_E = 32'd4; #1;
    check_output("beq uses fwd B", 32'(PCSrc_E), 32'd1);

    // Jump with negative offset.
    clear_inputs();
    Jump_E = 1; PC_E = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0; #1;
    check_output("jump PCSrc_E",    32'(PCSrc_E), 32'd1);
    check_output("jump PCTarget_E", PCTarget_E,   32'h0000_00F0);

    // Shift by immediate; store data is RD2, not the immediate.
    clear_inputs();
    ALUSrc_E = 1; Imm_Ext_E = 32'd3; RD1_E = 32'd1; RD2_E = 32'hAB;
    ALUControl_E = 3'b110; MemWrite_E = 1;
    tick();
    check_output("sll ALU_Result_M", ALU_Result_M, 32'd8);
    check_output("sll WriteData_M",  WriteData_M,  32'hAB);
    check_output("sll MemWrite_M",   32'(MemWrite_M), 32'd1);

    // Reset asserted mid-cycle has no effect until the next edge.
    rst = 1'b0;
    #2;
    check_output("async rst ignored", ALU_Result_M, 32'd8);
    tick();
    check_m_zero("mid reset");
    rst = 1'b1;

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 No parameters; all datapaths 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-004 RegWrite_E / RegWrite_M  in/out  1  register-file write enable, passed E to M.
REQ-005 MemWrite_E / MemWrite_M  in/out  1  data-memory write enable, passed E to M.
REQ-006 ResultSrc_E / ResultSrc_M  in/out  2  writeback select, passed E to M.
REQ-007 RD_E / RD_M  in/out  5  destination register index, passed E to M.
REQ-008 PCPlus4_E / PCPlus4_M  in/out  32  PC+4, passed E to M.
REQ-009 Branch_E  in  1  conditional-branch instruction.
REQ-010 Jump_E  in  1  unconditional jump.
REQ-011 ALUSrc_E  in  1  1 = ALU operand B from Imm_Ext_E.
REQ-012 ALUControl_E  in  3  ALU operation select.
REQ-013 Funct3_E  in  3  branch condition select.
REQ-014 ForwardA_E, ForwardB_E  in  2 each  operand forwarding selects from hazard unit.
REQ-015 RD1_E, RD2_E  in  32 each  register-file read data.
REQ-016 Imm_Ext_E  in  32  sign-extended immediate.
REQ-017 PC_E  in  32  instruction PC.
REQ-018 ResultW  in  32  writeback-stage result for forwarding.
REQ-019 ALU_Result_M  out  32  registered ALU result; also the forwarding source for select 10.
REQ-020 WriteData_M  out  32  registered store data.
REQ-021 PCSrc_E  out  1  combinational redirect request to fetch.
REQ-022 PCTarget_E  out  32  combinational PC_E + Imm_Ext_E, modulo 2^32.

Function
REQ-023 SrcA = RD1_E / ResultW / ALU_Result_M for ForwardA_E = 00 / 01 / 10; 11 treated as 00.
REQ-024 Forwarded B uses the same encoding on RD2_E with ForwardB_E; SrcB = Imm_Ext_E if ALUSrc_E else forwarded B.
REQ-025 ALUControl_E: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt signed (result 0/1), 110 sll by SrcB[4:0], 111 srl by SrcB[4:0]; add/sub wrap modulo 2^32.
REQ-026 Branch condition from SrcA vs forwarded B: Funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 never taken.
REQ-027 PCSrc_E = Jump_E OR (Branch_E AND condition); purely combinational, same cycle.
REQ-028 Pipeline register E/M: on each rising clk with rst=1, capture RegWrite, MemWrite, ResultSrc, RD, PCPlus4, ALU result, forwarded B (not SrcB) into the _M outputs; latency exactly 1 cycle.
REQ-029 No stall or flush inputs; the register loads every cycle.
REQ-030 Forwarding select 10 uses ALU_Result_M as held before the current edge (previous instruction's result).

Reset
REQ-031 When rst=0 at a rising edge, all _M outputs become 0 on that edge, irrespective of inputs; asynchronous rst changes have no effect until the next edge.
REQ-032 Combinational outputs PCSrc_E, PCTarget_E follow inputs during reset.

Verification
REQ-033 rst=0 for 2 edges with random inputs -> all _M outputs 0; rst released -> next edge loads inputs.
REQ-034 RD1=7, RD2=5, ALUControl=001, ALUSrc=0, Fwd=00 -> ALU_Result_M=2, WriteData_M=5 one cycle later.
REQ-035 ALU_Result_M=0x10, ResultW=0x20, ForwardA=10, ForwardB=01, add -> ALU_Result_M=0x30, WriteData_M=0x20.
REQ-036 Branch=1, Funct3=100, SrcA=0xFFFFFFFF, B=1 -> PCSrc_E=1; Funct3=110 same operands -> PCSrc_E=0.
REQ-037 Jump=1, PC_E=0x100, Imm=0xFFFFFFF0 -> PCSrc_E=1, PCTarget_E=0xF0 same cycle.
REQ-038 ALUSrc=1, Imm=3, RD1=1, sll, MemWrite=1, RD2=0xAB -> ALU_Result_M=8, WriteData_M=0xAB, MemWrite_M=1.
